// File: rtl/sr_arb_pkg.sv
// Shared definitions for the shift-register arbiter: state encodings and
// width helpers used by the arbiter and its round-robin encoder.
package sr_arb_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_LATCH  = 3'd5;
  localparam logic [2:0] S_ABORT  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_LOAD   = S_LOAD,
    ST_SETTLE = S_SETTLE,
    ST_DRAIN  = S_DRAIN,
    ST_HOLD   = S_HOLD,
    ST_LATCH  = S_LATCH,
    ST_ABORT  = S_ABORT
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Vector widths must be at least one bit even when the range collapses.
  function automatic int unsigned width_of(input int unsigned v);
    return (clog2(v) == 0) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/sr_arb_rr_pick.sv
// Combinational round-robin encoder: returns the lowest requesting index at
// or above i_ptr, wrapping modulo N (N need not be a power of two).
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic          o_valid,
  output logic [PW-1:0] o_idx
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_k;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_sum   = '0;
    w_k     = '0;
    for (int unsigned off = N; off > 0; off--) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(off - 1);
      if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
      w_k = w_sum[PW-1:0];
      if (i_req[w_k]) begin
        o_valid = 1'b1;
        o_idx   = w_k;
      end
    end
  end

endmodule

// File: rtl/sr_arb.sv
// Round-robin arbiter/sequencer sharing one display shift register between
// N_REQ frame producers; feeds words via load/busy and latches per frame.
module sr_arb
  import sr_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned DW           = 8,
  parameter int unsigned HOLD_TIMEOUT = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [N_REQ-1:0]            i_last,
  input  logic [N_REQ*DW-1:0]         i_data,
  output logic [N_REQ-1:0]            o_ack,
  output logic [width_of(N_REQ)-1:0]  o_grant_id,
  output logic                        o_abort,
  output logic [DW-1:0]               o_sr_data,
  output logic                        o_sr_load,
  input  logic                        i_sr_busy,
  output logic                        o_sr_latch
);

  localparam int unsigned GW = width_of(N_REQ);
  localparam int unsigned TW = width_of(HOLD_TIMEOUT + 1);

  state_t          r_state;
  logic [GW-1:0]   r_ptr;
  logic [GW-1:0]   r_grant;
  logic [DW-1:0]   r_data;
  logic            r_last;
  logic [TW-1:0]   r_timer;

  logic            w_pick_valid;
  logic [GW-1:0]   w_pick_idx;
  logic [GW-1:0]   w_sel;
  logic            w_sel_req;
  logic            w_sel_last;
  logic [DW-1:0]   w_sel_data;
  logic            w_expire;

  rr_pick #(.N(N_REQ), .PW(GW)) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // In IDLE the candidate is the round-robin pick; mid-frame only the owner.
  always_comb begin
    w_sel      = (r_state == ST_IDLE) ? w_pick_idx : r_grant;
    w_sel_req  = 1'b0;
    w_sel_last = 1'b0;
    w_sel_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_sel == GW'(k)) begin
        w_sel_req  = i_req[k];
        w_sel_last = i_last[k];
        w_sel_data = i_data[k*DW +: DW];
      end
    end
  end

  assign w_expire = (HOLD_TIMEOUT != 0) && (r_timer == TW'(HOLD_TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_timer <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid && !i_sr_busy) begin
            r_grant <= w_pick_idx;
            r_data  <= w_sel_data;
            r_last  <= w_sel_last;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD:   r_state <= ST_SETTLE;
        ST_SETTLE: r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!i_sr_busy) begin
            if (r_last) begin
              r_state <= ST_LATCH;
            end else if (w_sel_req) begin
              r_data  <= w_sel_data;
              r_last  <= w_sel_last;
              r_state <= ST_LOAD;
            end else begin
              r_timer <= '0;
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // A request on the expiry cycle still wins over the abort.
          if (w_sel_req) begin
            r_data  <= w_sel_data;
            r_last  <= w_sel_last;
            r_state <= ST_LOAD;
          end else if (w_expire) begin
            r_state <= ST_ABORT;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_LATCH, ST_ABORT: begin
          r_ptr   <= (r_grant == GW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_sr_load  = (r_state == ST_LOAD);
  assign o_sr_latch = (r_state == ST_LATCH);
  assign o_abort    = (r_state == ST_ABORT);
  assign o_ack      = o_sr_load ? (N_REQ'(1) << r_grant) : '0;
  assign o_grant_id = r_grant;
  assign o_sr_data  = r_data;

endmodule

// File: tb/tb_sr_arb.sv
// Self-checking bench for sr_arb: directed scenarios plus randomized frame
// traffic checked against a frame-level timing model of the arbiter.
module tb_sr_arb;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int HT = 4;

  typedef struct {
    logic [7:0]  d;
    logic        l;
    int unsigned g;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  last = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0]  ack;
  logic [1:0]    gid;
  logic          abort;
  logic [DW-1:0] sr_data;
  logic          sr_load;
  logic          sr_busy;
  logic          latch;

  int checks = 0;
  int errors = 0;

  word_t       wq[N][$];
  int unsigned wt[N];

  sr_arb #(.N_REQ(N), .DW(DW), .HOLD_TIMEOUT(HT)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_last     (last),
    .i_data     (data),
    .o_ack      (ack),
    .o_grant_id (gid),
    .o_abort    (abort),
    .o_sr_data  (sr_data),
    .o_sr_load  (sr_load),
    .i_sr_busy  (sr_busy),
    .o_sr_latch (latch)
  );

  always #5 clk = ~clk;

  // Shift-register model: busy rises the cycle after load, high for 8 cycles.
  logic        load_seen = 1'b0;
  int unsigned bcnt = 0;
  always @(posedge clk) begin
    load_seen <= sr_load;
    if (load_seen) bcnt <= 8;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign sr_busy = (bcnt != 0);

  task automatic do_reset();
    req = '0; last = '0; data = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 40 && sr_busy; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic void drive_producers();
    for (int k = 0; k < N; k++) begin
      if (wq[k].size() > 0 && wt[k] == 0) begin
        req[k] = 1'b1;
        last[k] = wq[k][0].l;
        data[k*DW +: DW] = wq[k][0].d;
      end else begin
        req[k] = 1'b0;
      end
    end
  endfunction

  task automatic test_reset();
    req = '1; last = '1; data = '1;
    @(negedge clk);
    checks++;
    if ({ack, gid, abort, sr_data, sr_load, latch} !== 16'h0) begin
      errors++;
      $display("FAIL reset_assert got %h exp 0000", {ack, gid, abort, sr_data, sr_load, latch});
    end
    req = '0; last = '0; data = '0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ack, gid, abort, sr_data, sr_load, latch} !== 16'h0) begin
      errors++;
      $display("FAIL reset_idle got %h exp 0000", {ack, gid, abort, sr_data, sr_load, latch});
    end
  endtask

  task automatic test_single_word();
    int ld = -1, lt = -1, nl = 0;
    do_reset();
    req = 3'b001; last = 3'b001; data = 24'h0000A5;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (sr_load) begin
        if (ld < 0) ld = n;
        checks++;
        if ({sr_data, ack} !== {8'hA5, 3'b001}) begin
          errors++;
          $display("FAIL single_load_word got %h/%b exp a5/001", sr_data, ack);
        end
        req = '0;
      end
      if (latch) begin nl++; lt = n; end
    end
    checks++;
    if (ld !== 1) begin
      errors++;
      $display("FAIL single_req_to_load got cycle %0d exp 1", ld);
    end
    checks++;
    if (nl !== 1 || lt !== ld + 11) begin
      errors++;
      $display("FAIL single_latch got %0d pulses at %0d exp 1 at %0d", nl, lt, ld + 11);
    end
  endtask

  task automatic test_fairness();
    int nl = 0, exp_id;
    do_reset();
    req = 3'b011; last = 3'b011; data = 24'h002010;
    for (int n = 0; n < 300 && nl < 8; n++) begin
      @(negedge clk);
      if (sr_load) begin
        exp_id = nl % 2;
        checks++;
        if ({gid, ack, sr_data} !== {2'(exp_id), 3'(1 << exp_id), (exp_id == 1) ? 8'h20 : 8'h10}) begin
          errors++;
          $display("FAIL fairness_grant frame %0d got id %0d ack %b exp id %0d", nl, gid, ack, exp_id);
        end
        nl++;
      end
    end
    checks++;
    if (nl !== 8) begin
      errors++;
      $display("FAIL fairness_frames got %0d exp 8", nl);
    end
    req = '0;
  endtask

  task automatic test_hold_timeout();
    int ld = -1, ab = -1, ld2 = -1, nlat = 0, nld = 0, nab = 0;
    do_reset();
    req = 3'b001; last = 3'b000; data = 24'h000011;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (sr_load) begin
        nld++;
        if (nld == 1) begin
          ld = n; req = 3'b010; last = 3'b010; data = 24'h002211;
        end else if (nld == 2) begin
          ld2 = n;
          checks++;
          if ({gid, ack, sr_data} !== {2'd1, 3'b010, 8'h22}) begin
            errors++;
            $display("FAIL hold_next_grant got id %0d ack %b data %h exp 1 010 22", gid, ack, sr_data);
          end
          req = '0;
        end
      end
      if (latch && ld2 < 0) nlat++;
      if (abort) begin
        nab++;
        if (ab < 0) ab = n;
        req = 3'b011; last = 3'b011; data = 24'h002233;
      end
    end
    checks++;
    if (ab !== ld + 11 + HT || nab !== 1) begin
      errors++;
      $display("FAIL hold_abort got %0d pulses first at %0d exp 1 at %0d", nab, ab, ld + 11 + HT);
    end
    checks++;
    if (nlat !== 0) begin
      errors++;
      $display("FAIL hold_no_latch got %0d exp 0", nlat);
    end
    checks++;
    if (ld2 !== ab + 2) begin
      errors++;
      $display("FAIL hold_regrant_cycle got %0d exp %0d", ld2, ab + 2);
    end
  endtask

  task automatic test_timeout_race();
    int ld = -1, ld2 = -1, lt = -1, nld = 0, nab = 0, nlat = 0;
    do_reset();
    req = 3'b001; last = 3'b000; data = 24'h000044;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (sr_load) begin
        nld++;
        if (nld == 1) begin
          ld = n; req = '0;
        end else if (nld == 2) begin
          ld2 = n;
          checks++;
          if ({ack, sr_data} !== {3'b001, 8'h55}) begin
            errors++;
            $display("FAIL race_word got %b/%h exp 001/55", ack, sr_data);
          end
          req = '0;
        end
      end
      if (abort) nab++;
      if (latch) begin nlat++; lt = n; end
      if (ld > 0 && n == ld + 10 + HT) begin
        req = 3'b001; last = 3'b001; data = 24'h000055;
      end
    end
    checks++;
    if (ld2 !== ld + 11 + HT || nab !== 0) begin
      errors++;
      $display("FAIL race_request_wins got load %0d aborts %0d exp load %0d aborts 0", ld2, nab, ld + 11 + HT);
    end
    checks++;
    if (nlat !== 1 || lt !== ld2 + 11) begin
      errors++;
      $display("FAIL race_latch got %0d at %0d exp 1 at %0d", nlat, lt, ld2 + 11);
    end
  endtask

  task automatic test_reset_mid_frame();
    int ld = -1, ld2 = -1, nld = 0, nlat = 0, early = 0;
    logic pbusy;
    do_reset();
    pbusy = sr_busy;
    req = 3'b001; last = 3'b001; data = 24'h000066;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (sr_load) begin
        nld++;
        if (pbusy) early++;
        if (nld == 1) begin
          ld = n; req = '0;
        end else if (nld == 2) begin
          ld2 = n;
          checks++;
          if ({ack, sr_data} !== {3'b001, 8'h77}) begin
            errors++;
            $display("FAIL rstmid_word got %b/%h exp 001/77", ack, sr_data);
          end
          req = '0;
        end
      end
      if (latch && ld2 < 0) nlat++;
      if (ld > 0 && n == ld + 4) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, gid, abort, sr_data, sr_load, latch} !== 16'h0) begin
          errors++;
          $display("FAIL rstmid_outputs got %h exp 0000", {ack, gid, abort, sr_data, sr_load, latch});
        end
      end
      if (ld > 0 && n == ld + 5) rst_n = 1'b1;
      if (ld > 0 && n == ld + 6) begin
        req = 3'b001; last = 3'b001; data = 24'h000077;
      end
      pbusy = sr_busy;
    end
    checks++;
    if (ld2 !== ld + 11 || early !== 0) begin
      errors++;
      $display("FAIL rstmid_wait_busy got load %0d early %0d exp load %0d early 0", ld2, early, ld + 11);
    end
    checks++;
    if (nlat !== 0) begin
      errors++;
      $display("FAIL rstmid_no_latch got %0d exp 0", nlat);
    end
  endtask

  task automatic test_random_traffic();
    int c, idle_from, evt_c, evt, ptr, own, g, r, nf, len;
    logic [N-1:0] preq, exp_ack, aobs;
    logic pbusy, exp_load, exp_abort, exp_latch, in_frame, done, abobs;
    logic [1:0] gobs;
    word_t w, tmp;
    do_reset();
    for (int k = 0; k < N; k++) begin
      wq[k].delete();
      nf = $urandom_range(4, 6);
      for (int f = 0; f < nf; f++) begin
        len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) begin
          w.d = 8'($urandom);
          w.l = (i == len - 1);
          w.g = (i == 0) ? $urandom_range(0, 3) : $urandom_range(0, 16);
          wq[k].push_back(w);
        end
      end
      wt[k] = wq[k][0].g;
    end
    drive_producers();
    preq = req; pbusy = sr_busy;
    c = 0; idle_from = 0; in_frame = 0; ptr = 0; own = 0; evt = 0; evt_c = 0; done = 0;
    for (int n = 0; n < 5000 && !done; n++) begin
      @(negedge clk);
      c++;
      exp_load = 0; exp_abort = 0; exp_latch = 0;
      if (!in_frame) begin
        if (c - 1 >= idle_from && preq != '0 && !pbusy) begin
          for (int i = N - 1; i >= 0; i--) if (preq[(ptr + i) % N]) own = (ptr + i) % N;
          exp_load = 1; in_frame = 1;
        end
      end else if (c == evt_c) begin
        exp_load = (evt == 1); exp_abort = (evt == 2); exp_latch = (evt == 3);
      end
      exp_ack = exp_load ? N'(1 << own) : '0;
      checks++;
      if ({sr_load, ack, abort, latch} !== {exp_load, exp_ack, exp_abort, exp_latch}) begin
        errors++;
        $display("FAIL rand_ctrl cycle %0d got load %b ack %b abort %b latch %b exp %b %b %b %b",
                 c, sr_load, ack, abort, latch, exp_load, exp_ack, exp_abort, exp_latch);
      end
      if (exp_load) begin
        checks++;
        if ({gid, sr_data} !== {2'(own), wq[own][0].d}) begin
          errors++;
          $display("FAIL rand_word cycle %0d got id %0d data %h exp id %0d data %h",
                   c, gid, sr_data, own, wq[own][0].d);
        end
        if (wq[own][0].l) begin
          evt = 3; evt_c = c + 11;
        end else begin
          g = (wq[own].size() > 1) ? int'(wq[own][1].g) : 1000;
          r = c + 1 + g;
          if (r <= c + 10) begin evt = 1; evt_c = c + 11; end
          else if (r <= c + 10 + HT) begin evt = 1; evt_c = r + 1; end
          else begin evt = 2; evt_c = c + 11 + HT; end
        end
      end
      if (exp_latch || exp_abort) begin
        ptr = (own + 1) % N; in_frame = 0; idle_from = c + 1;
      end
      preq = req; pbusy = sr_busy;
      aobs = ack; abobs = abort; gobs = gid;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (aobs[k] && wq[k].size() > 0) begin
          tmp = wq[k].pop_front();
          if (wq[k].size() > 0) wt[k] = wq[k][0].g;
        end else if (wt[k] > 0) begin
          wt[k]--;
        end
      end
      // An aborted frame is abandoned by its producer.
      if (abobs && gobs < N) begin
        while (wq[gobs].size() > 0) begin
          tmp = wq[gobs].pop_front();
          if (tmp.l) break;
        end
        if (wq[gobs].size() > 0) wt[gobs] = wq[gobs][0].g;
      end
      drive_producers();
      done = !in_frame;
      for (int k = 0; k < N; k++) if (wq[k].size() > 0) done = 0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rand_complete got frames pending at cycle %0d exp all drained", c);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fairness();
    test_hold_timeout();
    test_timeout_race();
    test_reset_mid_frame();
    test_random_traffic();
    test_random_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_arb.md
# sr_arb

Round-robin arbiter and sequencer that shares the single display shift register between N_REQ frame producers (digit refresh, status LEDs, debug). It accepts multi-word frames, feeds them one word at a time to the shift register through its load/busy handshake, and pulses the output latch once per completed frame. It sits between the producers and the shift-register driver and is the only block that drives that driver's load and latch inputs.

## Interface
- N_REQ, 2: number of requesters, 2..8.
- DW, 8: shift-register word width.
- HOLD_TIMEOUT, 64: maximum cycles a granted owner may leave its next word absent mid-frame; 0 disables the timeout.
- Reset: one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  N_REQ  per-requester word valid; held until the matching o_ack.
- i_last  in  N_REQ  qualifies i_req: this word ends the frame.
- i_data  in  N_REQ*DW  per-requester word; requester k uses bits [k*DW +: DW].
- o_ack  out  N_REQ  one-cycle pulse: word captured.
- o_grant_id  out  clog2(N_REQ)  current or most recent owner.
- o_abort  out  1  one-cycle pulse: frame dropped on timeout.
- o_sr_data  out  DW  word presented to the shift register.
- o_sr_load  out  1  one-cycle load strobe.
- i_sr_busy  in  1  shift register shifting; must rise no later than 1 cycle after o_sr_load is sampled.
- o_sr_latch  out  1  one-cycle latch pulse after the last word of a frame has shifted out.

## Operation
- States: IDLE, LOAD, SETTLE, DRAIN, HOLD, LATCH, ABORT.
- IDLE: if any i_req is set and i_sr_busy=0, pick the owner by round-robin (lowest index at or above rr_ptr, wrapping), capture that requester's word and last flag, set o_grant_id, and go to LOAD. Otherwise stay in IDLE.
- LOAD: o_sr_load=1 and o_ack[owner]=1 for exactly this cycle. Next state is SETTLE.
- SETTLE: one cycle in which i_sr_busy is ignored. Next state is DRAIN.
- DRAIN: wait for i_sr_busy=0.
  - If the captured last flag is set, go to LATCH.
  - Else if i_req[owner] is set, capture the new word and last flag and go to LOAD.
  - Else go to HOLD and clear the hold timer.
- HOLD: if i_req[owner] is set, capture and go to LOAD; otherwise the timer increments.
  - When the timer reaches HOLD_TIMEOUT-1 with no request, go to ABORT.
  - If a request arrives in the same cycle as expiry, the request wins.
- LATCH: o_sr_latch=1 for one cycle, rr_ptr becomes (owner+1) mod N_REQ, then IDLE.
- ABORT: o_abort=1 for one cycle, no latch pulse, rr_ptr advances as in LATCH, then IDLE.
- Non-owner requests during a frame are ignored and are never acked. A frame is atomic: no interleaving between requesters.
- o_sr_data holds the last captured word until the next capture.
- Arithmetic: rr_ptr wraps modulo N_REQ, including non-power-of-2 values. The timer is clog2(HOLD_TIMEOUT+1) bits wide and saturates; it never wraps.

## Timing
- Reset values: state IDLE, rr_ptr 0, timer 0, and all outputs 0 (o_ack, o_grant_id, o_abort, o_sr_data, o_sr_load, o_sr_latch).
- Request to load: i_req sampled in IDLE at edge t gives o_sr_load and o_ack high in cycle t+1.
- Word spacing is at least 3 cycles (LOAD, SETTLE, DRAIN) plus the shift time.
- LATCH follows, by 1 cycle, the first DRAIN cycle with i_sr_busy=0 after the last word.
- The requester may change i_data, i_last or i_req on the edge that ends its ack cycle.
- Reset mid-frame: return to IDLE immediately and emit no latch pulse. Because IDLE waits for i_sr_busy=0, a shift interrupted by reset is never overrun.

## Structure
- Package sr_arb_pkg holds:
  - the state enum;
  - the encodings for IDLE, LOAD, SETTLE, DRAIN, HOLD, LATCH and ABORT;
  - a clog2 helper for the grant and timer widths.
- Sub-module rr_pick: combinational round-robin encoder taking (req vector, rr_ptr) and producing (valid, index). It is reusable by other shared-resource arbiters.

## Test plan
Shift-register model: i_sr_busy rises the cycle after load and stays high for 8 cycles.
- Single-word frame: req0=1, last0=1, data0=0xA5 -> load with o_sr_data=0xA5 one cycle later, then one o_sr_latch pulse 11 cycles after the load.
- Contention: req0 and req1 both set from reset, 2-word frames -> full frame0 (2 acks), one latch, then frame1; req1 is never acked during frame0.
- Fairness: both requesters continuously request 1-word frames -> grants alternate 0,1,0,1 over 8 frames.
- Hold timeout: HOLD_TIMEOUT=4, owner sends a non-last word and then stops -> o_abort pulse once the hold timer reaches 3 (4 HOLD cycles) with no request, no latch, and the other requester is granted next.
- Timeout race: the owner's request lands on the expiry cycle -> word is acked and there is no abort.
- Reset mid-frame: i_rst_n low during DRAIN with busy high -> outputs 0 and no load issued until busy falls.
